// File: rtl/psum_pkg.sv
// rtl/psum_pkg.sv - shared types and constants for the psum drain controller
package psum_pkg;

   localparam int COL     = 8;
   localparam int PSUM_BW = 16;
   localparam int ADDR_W  = 11;
   localparam int CNT_W   = 11;

   function automatic int psum_max(input int bw);
      return (1 << (bw - 1)) - 1;
   endfunction

   function automatic int psum_min(input int bw);
      return -(1 << (bw - 1));
   endfunction

   localparam int PSUM_MAX = psum_max(PSUM_BW);
   localparam int PSUM_MIN = psum_min(PSUM_BW);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WAIT  = 3'd1,
      ST_READ  = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

endpackage

// File: rtl/psum_lane_addsat.sv
// rtl/psum_lane_addsat.sv - one lane: signed saturating add, first-pass bypass, ReLU
module psum_lane_addsat
   import psum_pkg::*;
#(
   parameter int psum_bw = PSUM_BW
) (
   input  logic [psum_bw-1:0] stored_i,
   input  logic [psum_bw-1:0] new_i,
   input  logic               bypass_i,
   input  logic               relu_en_i,
   output logic [psum_bw-1:0] result_o
);

   localparam logic [psum_bw-1:0] LANE_MAX = psum_bw'(psum_max(psum_bw));
   localparam logic [psum_bw-1:0] LANE_MIN = psum_bw'(psum_min(psum_bw));

   logic [psum_bw:0]   sum_w;
   logic [psum_bw-1:0] pre_w;

   // Sign-extended add; overflow shows as disagreement of the top two bits.
   always_comb begin
      sum_w = {stored_i[psum_bw-1], stored_i} + {new_i[psum_bw-1], new_i};
      pre_w = sum_w[psum_bw-1:0];
      if (bypass_i) begin
         pre_w = new_i;
      end else if (sum_w[psum_bw] != sum_w[psum_bw-1]) begin
         pre_w = sum_w[psum_bw] ? LANE_MIN : LANE_MAX;
      end
      result_o = (relu_en_i && pre_w[psum_bw-1]) ? '0 : pre_w;
   end

endmodule

// File: rtl/psum_accum_ctrl.sv
// rtl/psum_accum_ctrl.sv - OFIFO-to-psum-SRAM accumulate controller with start/done handshake
module psum_accum_ctrl
   import psum_pkg::*;
#(
   parameter int col     = COL,
   parameter int psum_bw = PSUM_BW,
   parameter int addr_w  = ADDR_W,
   parameter int cnt_w   = CNT_W
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [addr_w-1:0]      base_addr,
   input  logic [cnt_w-1:0]       num_rows,
   input  logic                   first_pass,
   input  logic                   relu_en,
   input  logic                   ofifo_valid,
   input  logic [col*psum_bw-1:0] ofifo_data,
   output logic                   ofifo_rd,
   output logic                   pmem_cen,
   output logic                   pmem_wen,
   output logic [addr_w-1:0]      pmem_addr,
   output logic [col*psum_bw-1:0] pmem_d,
   input  logic [col*psum_bw-1:0] pmem_q,
   output logic                   busy,
   output logic                   done
);

   state_t                 state_q, state_d;
   logic [addr_w-1:0]      addr_q, addr_d;
   logic [addr_w-1:0]      last_addr_q, last_addr_d;
   logic [cnt_w-1:0]       cnt_q, cnt_d;
   logic [cnt_w-1:0]       num_rows_q, num_rows_d;
   logic                   first_pass_q, first_pass_d;
   logic                   relu_en_q, relu_en_d;
   logic [col*psum_bw-1:0] hold_q, hold_d;
   logic [col*psum_bw-1:0] lane_new_w, lane_res_w;
   logic                   advance_w;

   // First pass writes the OFIFO head straight through; otherwise add the held vector.
   assign lane_new_w = first_pass_q ? ofifo_data : hold_q;

   for (genvar i = 0; i < col; i++) begin : g_lane
      psum_lane_addsat #(.psum_bw(psum_bw)) u_lane (
         .stored_i  (pmem_q[i*psum_bw +: psum_bw]),
         .new_i     (lane_new_w[i*psum_bw +: psum_bw]),
         .bypass_i  (first_pass_q),
         .relu_en_i (relu_en_q),
         .result_o  (lane_res_w[i*psum_bw +: psum_bw])
      );
   end

   // State register plus latched pass configuration, counters and hold vector.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         last_addr_q  <= '0;
         cnt_q        <= '0;
         num_rows_q   <= '0;
         first_pass_q <= 1'b0;
         relu_en_q    <= 1'b0;
         hold_q       <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         last_addr_q  <= last_addr_d;
         cnt_q        <= cnt_d;
         num_rows_q   <= num_rows_d;
         first_pass_q <= first_pass_d;
         relu_en_q    <= relu_en_d;
         hold_q       <= hold_d;
      end
   end

   // Next-state and SRAM/OFIFO strobes; a READ with an empty head waits in place.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      last_addr_d  = last_addr_q;
      cnt_d        = cnt_q;
      num_rows_d   = num_rows_q;
      first_pass_d = first_pass_q;
      relu_en_d    = relu_en_q;
      hold_d       = hold_q;
      ofifo_rd     = 1'b0;
      pmem_cen     = 1'b1;
      pmem_wen     = 1'b1;
      busy         = 1'b1;
      done         = 1'b0;
      advance_w    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) begin
               addr_d       = base_addr;
               cnt_d        = '0;
               num_rows_d   = num_rows;
               first_pass_d = first_pass;
               relu_en_d    = relu_en;
               state_d      = (num_rows == '0) ? ST_DONE : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (ofifo_valid) state_d = ST_READ;
         end
         ST_READ: begin
            if (ofifo_valid) begin
               ofifo_rd = 1'b1;
               hold_d   = ofifo_data;
               pmem_cen = 1'b0;
               if (first_pass_q) begin
                  pmem_wen  = 1'b0;
                  advance_w = 1'b1;
               end else begin
                  state_d = ST_WRITE;
               end
            end
         end
         ST_WRITE: begin
            pmem_cen  = 1'b0;
            pmem_wen  = 1'b0;
            advance_w = 1'b1;
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (advance_w) begin
         addr_d = addr_q + 1'b1;
         cnt_d  = cnt_q + 1'b1;
         if (cnt_q + 1'b1 == num_rows_q) state_d = ST_DONE;
         else if (ofifo_valid)           state_d = ST_READ;
         else                            state_d = ST_WAIT;
      end

      if (!pmem_cen) last_addr_d = addr_q;
      pmem_addr = pmem_cen ? last_addr_q : addr_q;
      pmem_d    = pmem_wen ? '0 : lane_res_w;
   end

endmodule

// File: tb/tb_psum_accum_ctrl.sv
// tb/tb_psum_accum_ctrl.sv - scoreboard bench for psum_accum_ctrl
module tb_psum_accum_ctrl;
   import psum_pkg::*;

   localparam int W     = COL * PSUM_BW;
   localparam int DEPTH = 1 << ADDR_W;

   typedef logic [W-1:0] vec_t;
   typedef struct {
      logic [ADDR_W-1:0] addr;
      vec_t              data;
   } wr_t;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [CNT_W-1:0]  num_rows = '0;
   logic              first_pass = 1'b0;
   logic              relu_en = 1'b0;
   logic              ofifo_valid = 1'b0;
   vec_t              ofifo_data = '0;
   logic              ofifo_rd;
   logic              pmem_cen, pmem_wen;
   logic [ADDR_W-1:0] pmem_addr;
   vec_t              pmem_d;
   vec_t              pmem_q = '0;
   logic              busy, done;

   psum_accum_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .base_addr   (base_addr),
      .num_rows    (num_rows),
      .first_pass  (first_pass),
      .relu_en     (relu_en),
      .ofifo_valid (ofifo_valid),
      .ofifo_data  (ofifo_data),
      .ofifo_rd    (ofifo_rd),
      .pmem_cen    (pmem_cen),
      .pmem_wen    (pmem_wen),
      .pmem_addr   (pmem_addr),
      .pmem_d      (pmem_d),
      .pmem_q      (pmem_q),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_errors = 0;
   vec_t sram    [DEPTH];
   vec_t ref_mem [DEPTH];
   vec_t fifo [$];
   vec_t vecs [$];
   wr_t  exp_q [$];
   int   wr_total = 0;
   int   rd_total = 0;
   int   wr0, rd0;
   logic prev_rd = 1'b0;
   logic [ADDR_W-1:0] prev_addr = '0;
   wr_t  mon_e;

   task automatic check(input string tag, input vec_t obs, input vec_t exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic vec_t set_lane(input vec_t v, input int lane, input int val);
      vec_t r;
      r = v;
      r[lane*PSUM_BW +: PSUM_BW] = val[PSUM_BW-1:0];
      return r;
   endfunction

   function automatic vec_t rnd_vec();
      vec_t r;
      r = '0;
      for (int i = 0; i < COL; i++) r = set_lane(r, i, int'($urandom_range(0, 200)) - 100);
      return r;
   endfunction

   function automatic vec_t model_vec(input vec_t stored, input vec_t inc, input bit first, input bit relu);
      vec_t r;
      int   s;
      r = '0;
      for (int i = 0; i < COL; i++) begin
         s = int'($signed(inc[i*PSUM_BW +: PSUM_BW]));
         if (!first) s = s + int'($signed(stored[i*PSUM_BW +: PSUM_BW]));
         if (s > 32767)  s = 32767;
         if (s < -32768) s = -32768;
         if (relu && s < 0) s = 0;
         r = set_lane(r, i, s);
      end
      return r;
   endfunction

   // SRAM and show-ahead OFIFO models
   always @(posedge clk) begin
      if (!pmem_cen) begin
         if (!pmem_wen) sram[pmem_addr] <= pmem_d;
         else           pmem_q <= sram[pmem_addr];
      end
      if (ofifo_rd && fifo.size() != 0) void'(fifo.pop_front());
      ofifo_valid <= (fifo.size() != 0);
      ofifo_data  <= (fifo.size() != 0) ? fifo[0] : '0;
   end

   // Write scoreboard and protocol monitor
   always @(negedge clk) begin
      if (reset) begin
         prev_rd <= 1'b0;
      end else begin
         if (prev_rd) check("wr_after_rd", vec_t'({pmem_wen, pmem_addr}), vec_t'({1'b0, prev_addr}));
         if (!pmem_wen) begin
            check("wr_cen", vec_t'(pmem_cen), vec_t'(0));
            if (exp_q.size() == 0) begin
               check("wr_unexpected", vec_t'(pmem_addr), vec_t'(DEPTH));
            end else begin
               mon_e = exp_q.pop_front();
               check("wr_addr", vec_t'(pmem_addr), vec_t'(mon_e.addr));
               check("wr_data", pmem_d, mon_e.data);
            end
            wr_total <= wr_total + 1;
         end else begin
            check("d_zero", pmem_d, vec_t'(0));
         end
         if (ofifo_rd) begin
            check("rd_valid", vec_t'(ofifo_valid), vec_t'(1));
            rd_total <= rd_total + 1;
         end
         prev_rd   <= !pmem_cen && pmem_wen;
         prev_addr <= pmem_addr;
      end
   end

   task automatic preload(input int a, input vec_t v);
      sram[a]    = v;
      ref_mem[a] = v;
   endtask

   task automatic start_pass(input int base, input int n, input bit first, input bit relu, input int npush);
      int  a;
      wr_t e;
      for (int i = 0; i < n; i++) begin
         a = (base + i) % DEPTH;
         ref_mem[a] = model_vec(ref_mem[a], vecs[i], first, relu);
         e.addr = a[ADDR_W-1:0];
         e.data = ref_mem[a];
         exp_q.push_back(e);
      end
      for (int i = 0; i < npush; i++) fifo.push_back(vecs[i]);
      @(negedge clk);
      base_addr  = base[ADDR_W-1:0];
      num_rows   = n[CNT_W-1:0];
      first_pass = first;
      relu_en    = relu;
      start      = 1'b1;
      wr0 = wr_total;
      rd0 = rd_total;
      @(negedge clk);
      start      = 1'b0;
      base_addr  = '1;
      num_rows   = '1;
      first_pass = ~first;
      relu_en    = ~relu;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 1;
      while (!done && cyc < 60) begin
         @(negedge clk);
         cyc++;
      end
      if (!done) check("done_timeout", vec_t'(done), vec_t'(1));
   endtask

   task automatic finish_pass(input string tag, input int exp_cyc, input int rows);
      int cyc;
      wait_done(cyc);
      if (exp_cyc > 0) check({tag, "_cycles"}, vec_t'(cyc), vec_t'(exp_cyc));
      check({tag, "_rd_cnt"}, vec_t'(rd_total - rd0), vec_t'(rows));
      check({tag, "_wr_cnt"}, vec_t'(wr_total - wr0), vec_t'(rows));
      @(negedge clk);
      check({tag, "_done_once"}, vec_t'({done, busy}), vec_t'(0));
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_rd"},   vec_t'(ofifo_rd), vec_t'(0));
      check({tag, "_cen"},  vec_t'(pmem_cen), vec_t'(1));
      check({tag, "_wen"},  vec_t'(pmem_wen), vec_t'(1));
      check({tag, "_addr"}, vec_t'(pmem_addr), vec_t'(0));
      check({tag, "_d"},    pmem_d, vec_t'(0));
      check({tag, "_busy"}, vec_t'(busy), vec_t'(0));
      check({tag, "_done"}, vec_t'(done), vec_t'(0));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      for (int i = 0; i < DEPTH; i++) preload(i, '0);
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      reset = 1'b0;
      @(negedge clk);

      // First pass, lane0 = 10, -4, 7 at 5..7
      vecs.delete();
      vecs.push_back(set_lane(rnd_vec(), 0, 10));
      vecs.push_back(set_lane(rnd_vec(), 0, -4));
      vecs.push_back(set_lane(rnd_vec(), 0, 7));
      start_pass(5, 3, 1'b1, 1'b0, 3);
      finish_pass("first", 5, 3);
      check("first_l0_a5", vec_t'(sram[5][15:0]), vec_t'(16'd10));
      check("first_l0_a6", vec_t'(sram[6][15:0]), vec_t'(16'hFFFC));
      check("first_l0_a7", vec_t'(sram[7][15:0]), vec_t'(16'd7));

      // Accumulate 100 + -30
      preload(5, set_lane(rnd_vec(), 0, 100));
      vecs.delete();
      vecs.push_back(set_lane(rnd_vec(), 0, -30));
      start_pass(5, 1, 1'b0, 1'b0, 1);
      finish_pass("acc", 4, 1);
      check("acc_l0", vec_t'(sram[5][15:0]), vec_t'(16'd70));

      // Saturation on lane3
      preload(20, set_lane(rnd_vec(), 3, 32000));
      preload(21, set_lane(rnd_vec(), 3, -32000));
      vecs.delete();
      vecs.push_back(set_lane(rnd_vec(), 3, 1000));
      vecs.push_back(set_lane(rnd_vec(), 3, -1000));
      start_pass(20, 2, 1'b0, 1'b0, 2);
      finish_pass("sat", 6, 2);
      check("sat_pos", vec_t'(sram[20][63:48]), vec_t'(16'h7FFF));
      check("sat_neg", vec_t'(sram[21][63:48]), vec_t'(16'h8000));

      // ReLU on last pass
      preload(30, set_lane(rnd_vec(), 0, 5));
      preload(31, set_lane(rnd_vec(), 0, 5));
      vecs.delete();
      vecs.push_back(set_lane(rnd_vec(), 0, -9));
      vecs.push_back(set_lane(rnd_vec(), 0, 9));
      start_pass(30, 2, 1'b0, 1'b1, 2);
      finish_pass("relu", 6, 2);
      check("relu_neg", vec_t'(sram[30][15:0]), vec_t'(16'd0));
      check("relu_pos", vec_t'(sram[31][15:0]), vec_t'(16'd14));

      // OFIFO stall mid-pass, with an ignored start while busy
      vecs.delete();
      for (int i = 0; i < 4; i++) vecs.push_back(rnd_vec());
      start_pass(40, 4, 1'b0, 1'b0, 2);
      k = 0;
      while (!(busy && !ofifo_valid && pmem_cen && (rd_total - rd0) == 2) && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("stall_reach", vec_t'(k < 50), vec_t'(1));
      for (int c = 0; c < 4; c++) begin
         check("stall_cen",  vec_t'(pmem_cen), vec_t'(1));
         check("stall_rd",   vec_t'(ofifo_rd), vec_t'(0));
         check("stall_busy", vec_t'(busy), vec_t'(1));
         check("stall_addr", vec_t'(pmem_addr), vec_t'(41));
         start     = (c == 1);
         base_addr = 11'd100;
         num_rows  = 11'd1;
         @(negedge clk);
         start = 1'b0;
      end
      fifo.push_back(vecs[2]);
      fifo.push_back(vecs[3]);
      finish_pass("stall", 0, 4);

      // Zero rows: done one cycle after start; start during DONE is ignored
      vecs.delete();
      start_pass(9, 0, 1'b0, 1'b0, 0);
      check("zero_done", vec_t'(done), vec_t'(1));
      start    = 1'b1;
      num_rows = 11'd1;
      @(negedge clk);
      start = 1'b0;
      check("zero_no_restart", vec_t'({done, busy}), vec_t'(0));
      check("zero_wr_cnt", vec_t'(wr_total - wr0), vec_t'(0));

      // Address wrap 2047 -> 0
      vecs.delete();
      vecs.push_back(rnd_vec());
      vecs.push_back(rnd_vec());
      start_pass(2047, 2, 1'b1, 1'b0, 2);
      finish_pass("wrap", 4, 2);

      // Reset asserted during WRITE
      vecs.delete();
      vecs.push_back(rnd_vec());
      vecs.push_back(rnd_vec());
      start_pass(50, 2, 1'b0, 1'b0, 2);
      k = 0;
      while (pmem_wen && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("rst_reach_write", vec_t'(pmem_wen), vec_t'(0));
      reset = 1'b1;
      @(negedge clk);
      check_reset_vals("midreset");
      reset = 1'b0;
      exp_q.delete();
      fifo.delete();
      @(negedge clk);

      // Recovery after reset
      vecs.delete();
      vecs.push_back(rnd_vec());
      start_pass(60, 1, 1'b1, 1'b1, 1);
      finish_pass("recover", 3, 1);
      check("exp_q_empty", vec_t'(exp_q.size()), vec_t'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
